// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: RV32 func3 size codes, FSM states
// and the access-legality check.
package mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Returns 1 for misaligned accesses, undefined size codes and unsigned stores.
  function automatic logic check_access(input logic [1:0] addr_lo,
                                        input logic [2:0] size,
                                        input logic       we);
    logic bad;
    case (size)
      SZ_B:         bad = 1'b0;
      SZ_H:         bad = addr_lo[0];
      SZ_W:         bad = (addr_lo != 2'b00);
      SZ_BU, SZ_HU: bad = we;
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_format.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it
// according to the RV32 load func3.
module mem_load_format
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    data = {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    data = {{16{half_sel[15]}}, half_sel};
      SZ_W:    data = word;
      SZ_BU:   data = {24'h0, byte_sel};
      SZ_HU:   data = {16'h0, half_sel};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder for the RV32 shared bus: byte-lane masked
// stores, extended loads, configurable wait states and a one-cycle rdy pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  output logic [31:0] rdata,
  output logic        rdy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  size_reg;
  logic        we_reg;
  logic [31:0] rdata_reg;
  logic        rdy_reg;
  logic        err_reg;

  logic          accept;
  logic          enter_resp;
  logic          commit;
  logic [31:0]   eff_addr;
  logic [31:0]   eff_wdata;
  logic [2:0]    eff_size;
  logic          eff_we;
  logic          eff_err;
  logic [AW-1:0] eff_idx;
  logic [3:0]    byte_en;
  logic [31:0]   wr_word;
  logic [31:0]   raw_word;
  logic [31:0]   load_data;
  logic          unused_addr_bits;

  assign accept     = req && (state_reg == S_IDLE || state_reg == S_RESP);
  assign enter_resp = (state_reg == S_WAIT && cnt_reg == 4'd0) ||
                      (accept && WAIT_STATES == 0);

  // With no wait states the accepting edge is also the response edge, so the
  // live bus fields stand in for the latched copy.
  assign eff_addr  = (WAIT_STATES == 0) ? addr  : addr_reg;
  assign eff_wdata = (WAIT_STATES == 0) ? wdata : wdata_reg;
  assign eff_size  = (WAIT_STATES == 0) ? size  : size_reg;
  assign eff_we    = (WAIT_STATES == 0) ? we    : we_reg;
  assign eff_idx   = eff_addr[AW+1:2];
  assign eff_err   = check_access(eff_addr[1:0], eff_size, eff_we);
  assign commit    = enter_resp && !reset && eff_we && !eff_err;
  assign unused_addr_bits = ^eff_addr[31:AW+2];

  always_comb begin
    byte_en = 4'b0000;
    wr_word = eff_wdata;
    case (eff_size)
      SZ_B: begin
        byte_en = 4'b0001 << eff_addr[1:0];
        wr_word = {4{eff_wdata[7:0]}};
      end
      SZ_H: begin
        byte_en = eff_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{eff_wdata[15:0]}};
      end
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // One byte-wide array per lane so each lane write-enable stays independent.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (commit && byte_en[gi]) begin
        mem_lane[eff_idx] <= wr_word[gi*8 +: 8];
      end
    end

    assign raw_word[gi*8 +: 8] = mem_lane[eff_idx];
  end

  mem_load_format u_load_format (
    .word    (raw_word),
    .addr_lo (eff_addr[1:0]),
    .size    (eff_size),
    .data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      size_reg  <= 3'b000;
      we_reg    <= 1'b0;
      rdata_reg <= 32'h0;
      rdy_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      rdy_reg <= enter_resp;
      err_reg <= enter_resp && eff_err;
      if (enter_resp) begin
        rdata_reg <= (eff_we || eff_err) ? 32'h0 : load_data;
      end
      case (state_reg)
        S_IDLE, S_RESP: begin
          if (accept) begin
            addr_reg  <= addr;
            wdata_reg <= wdata;
            size_reg  <= size;
            we_reg    <= we;
            if (WAIT_STATES == 0) begin
              state_reg <= S_RESP;
            end else begin
              cnt_reg   <= 4'(WAIT_STATES - 1);
              state_reg <= S_WAIT;
            end
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign rdy   = rdy_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with 0, 2 and 3 wait states
// sharing one clock and reset.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 0, we0 = 0, req2 = 0, we2 = 0, req3 = 0, we3 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr2 = 0, wdata2 = 0, addr3 = 0, wdata3 = 0;
  logic [2:0]  size0 = 0, size2 = 0, size3 = 0;
  logic [31:0] rdata0, rdata2, rdata3;
  logic        rdy0, err0, rdy2, err2, rdy3, err3;

  int checks = 0;
  int failures = 0;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .size(size0), .rdata(rdata0), .rdy(rdy0), .err(err0));
  mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .size(size2), .rdata(rdata2), .rdy(rdy2), .err(err2));
  mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .size(size3), .rdata(rdata3), .rdy(rdy3), .err(err3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single access on the zero-wait instance; response checked one cycle later.
  task automatic acc0(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] s,
                      input logic e_err, input logic [31:0] e_rdata);
    @(negedge clk);
    req0 = 1; we0 = w; addr0 = a; wdata0 = d; size0 = s;
    @(negedge clk);
    req0 = 0;
    check({tag, ".rdy"}, 32'(rdy0), 32'd1);
    check({tag, ".err"}, 32'(err0), 32'(e_err));
    check({tag, ".rdata"}, rdata0, e_rdata);
    $display("txn %s we=%0d addr=%h size=%0d rdy=%0d err=%0d rdata=%h",
             tag, w, a, s, rdy0, err0, rdata0);
  endtask

  // Single access on the two-wait instance; rdy must stay low until the third cycle.
  task automatic acc2(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] s, input logic [31:0] e_rdata);
    @(negedge clk);
    req2 = 1; we2 = w; addr2 = a; wdata2 = d; size2 = s;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req2 = 0;
      check({tag, ".rdy"}, 32'(rdy2), (i == 2) ? 32'd1 : 32'd0);
    end
    check({tag, ".rdata"}, rdata2, e_rdata);
    $display("txn %s we=%0d addr=%h rdy=%0d rdata=%h", tag, w, a, rdy2, rdata2);
  endtask

  initial begin
    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("rst.rdy0", 32'(rdy0), 32'd0);
    check("rst.err0", 32'(err0), 32'd0);
    check("rst.rdata0", rdata0, 32'd0);
    check("rst.state0", 32'(dut0.state_reg), 32'(S_IDLE));
    check("rst.rdy3", 32'(rdy3), 32'd0);
    check("rst.rdata3", rdata3, 32'd0);

    acc0("sw10", 1, 32'h10, 32'hDEADBEEF, SZ_W, 0, 32'h0);
    @(negedge clk);
    check("idle.rdy", 32'(rdy0), 32'd0);
    acc0("lw10", 0, 32'h10, 32'h0, SZ_W, 0, 32'hDEADBEEF);
    acc0("lb13", 0, 32'h13, 32'h0, SZ_B, 0, 32'hFFFFFFDE);
    acc0("lbu13", 0, 32'h13, 32'h0, SZ_BU, 0, 32'h000000DE);
    acc0("lh10", 0, 32'h10, 32'h0, SZ_H, 0, 32'hFFFFBEEF);
    acc0("lhu12", 0, 32'h12, 32'h0, SZ_HU, 0, 32'h0000DEAD);
    acc0("sb11", 1, 32'h11, 32'h55, SZ_B, 0, 32'h0);
    acc0("lw10b", 0, 32'h10, 32'h0, SZ_W, 0, 32'hDEAD55EF);
    acc0("sh12", 1, 32'h12, 32'h0000A5C3, SZ_H, 0, 32'h0);
    acc0("lw10h", 0, 32'h10, 32'h0, SZ_W, 0, 32'hA5C355EF);
    acc0("aliaslw", 0, 32'h1010, 32'h0, SZ_W, 0, 32'hA5C355EF);

    // Misaligned / illegal accesses must flag err and leave memory alone
    acc0("sw12mis", 1, 32'h12, 32'h11223344, SZ_W, 1, 32'h0);
    @(negedge clk);
    check("err.clear", 32'(err0), 32'd0);
    acc0("lw10mis", 0, 32'h10, 32'h0, SZ_W, 0, 32'hA5C355EF);
    acc0("sh13mis", 1, 32'h13, 32'h7777, SZ_H, 1, 32'h0);
    acc0("ld011", 0, 32'h10, 32'h0, 3'b011, 1, 32'h0);
    acc0("sbu", 1, 32'h10, 32'h99, SZ_BU, 1, 32'h0);
    acc0("lw10ill", 0, 32'h10, 32'h0, SZ_W, 0, 32'hA5C355EF);

    // Back-to-back with req held: store then load of the same word
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h12345678; size0 = SZ_W;
    @(negedge clk);
    check("b2b.rdy1", 32'(rdy0), 32'd1);
    we0 = 0; wdata0 = 32'h0;
    @(negedge clk);
    req0 = 0;
    check("b2b.rdy2", 32'(rdy0), 32'd1);
    check("b2b.rdata", rdata0, 32'h12345678);
    $display("txn b2b sw/lw addr=20 rdata=%h", rdata0);
    @(negedge clk);
    check("b2b.idle", 32'(rdy0), 32'd0);

    // Three wait states: store, then a load with req toggled during WAIT
    @(negedge clk);
    req3 = 1; we3 = 1; addr3 = 32'h40; wdata3 = 32'hCAFEF00D; size3 = SZ_W;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req3 = 0;
      check("ws3.sw.rdy", 32'(rdy3), (i == 3) ? 32'd1 : 32'd0);
    end
    $display("txn ws3 sw addr=40 rdy=%0d err=%0d", rdy3, err3);
    @(negedge clk);
    req3 = 1; we3 = 0; addr3 = 32'h40; size3 = SZ_W;
    @(negedge clk);
    req3 = 0;
    check("ws3.e0", 32'(rdy3), 32'd0);
    @(negedge clk);
    check("ws3.e1", 32'(rdy3), 32'd0);
    req3 = 1; addr3 = 32'h44;
    @(negedge clk);
    req3 = 0;
    check("ws3.e2", 32'(rdy3), 32'd0);
    @(negedge clk);
    check("ws3.e3", 32'(rdy3), 32'd1);
    check("ws3.rdata", rdata3, 32'hCAFEF00D);
    $display("txn ws3 lw addr=40 rdy=%0d rdata=%h", rdy3, rdata3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ws3.quiet", 32'(rdy3), 32'd0);
    end

    // Two wait states: a store aborted by reset during WAIT is discarded
    acc2("ws2.sw", 1, 32'h8, 32'h11111111, SZ_W, 32'h0);
    @(negedge clk);
    req2 = 1; we2 = 1; addr2 = 32'h8; wdata2 = 32'h22222222; size2 = SZ_W;
    @(negedge clk);
    req2 = 0;
    reset = 1;
    check("abort.rdy0", 32'(rdy2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort.rdy", 32'(rdy2), 32'd0);
    end
    reset = 0;
    @(negedge clk);
    check("abort.idle", 32'(rdy2), 32'd0);
    acc2("ws2.lw", 0, 32'h8, 32'h0, SZ_W, 32'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
